// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed 5-tap FIR controller: one shared multiplier and accumulator stepped over
// the taps, one tap per cycle, with valid/ready on both sides and runtime-writable coefficients.
// Optional build macro: FIR_SAT_EN makes the accumulator saturate instead of wrap.
module fir_mac_sequencer #(
  parameter int unsigned N = 4,  // integer bits of sample and coefficient
  parameter int unsigned M = 4   // fractional bits of sample and coefficient
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N+M-1:0]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*(N+M)-1:0] out_data,
  input  logic               coef_we,
  input  logic [2:0]         coef_addr,
  input  logic [N+M-1:0]     coef_wdata,
  output logic               coef_err,
  output logic               busy
);

  localparam int unsigned W    = N + M;
  localparam int unsigned AccW = 2 * W;
  localparam int unsigned Taps = 5;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      x_q [Taps];
  logic [W-1:0]      x_d [Taps];
  logic [W-1:0]      h_q [Taps];
  logic [W-1:0]      h_d [Taps];
  logic [AccW-1:0]   acc_q, acc_d;
  logic [2:0]        tap_q, tap_d;
  logic              coef_err_q, coef_err_d;

  logic [W-1:0]      x_sel, h_sel;
  logic [AccW-1:0]   prod;
  logic [AccW:0]     sum_full;
  logic [AccW-1:0]   acc_next;

  // Select the current tap's sample/coefficient pair and form the full-width product and sum.
  always_comb begin
    x_sel = '0;
    h_sel = '0;
    for (int k = 0; k < Taps; k++) begin
      if (tap_q == 3'(k)) begin
        x_sel = x_q[k];
        h_sel = h_q[k];
      end
    end
    prod     = AccW'(x_sel) * AccW'(h_sel);
    sum_full = {1'b0, acc_q} + {1'b0, prod};
`ifdef FIR_SAT_EN
    // Once saturated, acc is all-ones, so any further nonzero product carries out again.
    acc_next = sum_full[AccW] ? {AccW{1'b1}} : sum_full[AccW-1:0];
`else
    acc_next = sum_full[AccW-1:0];
`endif
  end

  // Next-state logic: FSM, delay line, accumulator and coefficient port.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    h_d        = h_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    coef_err_d = 1'b0;

    if (clr) begin
      // Flush drops everything in flight, including a same-cycle sample or write.
      state_d = StIdle;
      for (int k = 0; k < Taps; k++) x_d[k] = '0;
      acc_d = '0;
      tap_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            for (int k = Taps - 1; k > 0; k--) x_d[k] = x_q[k-1];
            x_d[0]  = in_data;
            acc_d   = '0;
            tap_d   = '0;
            state_d = StMac;
          end
        end
        StMac: begin
          acc_d = acc_next;
          if (tap_q == 3'(Taps - 1)) begin
            tap_d   = '0;
            state_d = StOut;
          end else begin
            tap_d = tap_q + 3'd1;
          end
        end
        StOut: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      // A write accepted alongside a sample lands before the first MAC, so it is used.
      if (coef_we) begin
        if (state_q == StIdle && coef_addr <= 3'(Taps - 1)) begin
          for (int k = 0; k < Taps; k++) begin
            if (coef_addr == 3'(k)) h_d[k] = coef_wdata;
          end
        end else begin
          coef_err_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset; coefficients return to their defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      tap_q      <= '0;
      coef_err_q <= 1'b0;
      for (int k = 0; k < Taps; k++) x_q[k] <= '0;
      h_q[0] <= W'(8'h03);
      h_q[1] <= W'(8'h01);
      h_q[2] <= W'(8'h80);
      h_q[3] <= W'(8'h01);
      h_q[4] <= W'(8'h03);
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      h_q        <= h_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      coef_err_q <= coef_err_d;
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StOut);
    busy      = (state_q != StIdle);
    out_data  = acc_q;
    coef_err  = coef_err_q;
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with n = m = 4.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic        coef_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  fir_mac_sequencer #(.N(4), .M(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Accept one sample from IDLE, wait (bounded) for out_valid, capture, then handshake if ready.
  task automatic run_sample(input logic [7:0] d, output int lat, output logic [15:0] y);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    y = out_data;
    if (out_ready) tick();
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (coef_err !== 1'b0) begin n_bad++; $display("FAIL reset_coef_err got=%b exp=0", coef_err); end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    logic [7:0]  din [5];
    logic [15:0] exp [5];
    logic [15:0] y;
    int lat;
    din = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    exp = '{16'h0030, 16'h0010, 16'h0800, 16'h0010, 16'h0030};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_sample(din[i], lat, y);
      n_cmp++; if (y !== exp[i]) begin n_bad++; $display("FAIL impulse_data[%0d] got=%h exp=%h", i, y, exp[i]); end
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL impulse_latency[%0d] got=%0d exp=6", i, lat); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL impulse_ready_after[%0d] got=%b exp=1", i, in_ready); end
    end
  endtask

  task automatic test_wrap_sat();
    logic [15:0] y, exp5;
    int lat;
`ifdef FIR_SAT_EN
    exp5 = 16'hFFFF;
`else
    exp5 = 16'hF605;
`endif
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) write_coef(3'(k), 8'hFF);
    run_sample(8'hFF, lat, y);
    n_cmp++; if (y !== 16'hFE01) begin n_bad++; $display("FAIL wrap_first got=%h exp=fe01", y); end
    for (int i = 1; i < 5; i++) run_sample(8'hFF, lat, y);
    n_cmp++; if (y !== exp5) begin n_bad++; $display("FAIL wrap_fifth got=%h exp=%h", y, exp5); end
  endtask

  task automatic test_backpressure();
    logic [15:0] y;
    int lat;
    do_reset();
    out_ready = 1'b0;
    run_sample(8'h10, lat, y);
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, out_valid); end
      n_cmp++; if (out_data !== 16'h0030) begin n_bad++; $display("FAIL bp_data[%0d] got=%h exp=0030", c, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy[%0d] got=%b exp=1", c, busy); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
    n_cmp++; if (out_data !== 16'h0030) begin n_bad++; $display("FAIL bp_retain_data got=%h exp=0030", out_data); end
  endtask

  task automatic test_coef_reject();
    logic [15:0] y;
    int lat;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    in_valid = 1'b0;
    write_coef(3'd0, 8'h55);  // issued during MAC: must be dropped
    n_cmp++; if (coef_err !== 1'b1) begin n_bad++; $display("FAIL rej_mac_err got=%b exp=1", coef_err); end
    tick();
    n_cmp++; if (coef_err !== 1'b0) begin n_bad++; $display("FAIL rej_mac_pulse got=%b exp=0", coef_err); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_cmp++; if (out_data !== 16'h0030) begin n_bad++; $display("FAIL rej_inflight got=%h exp=0030", out_data); end
    tick();
    write_coef(3'd5, 8'h55);
    n_cmp++; if (coef_err !== 1'b1) begin n_bad++; $display("FAIL rej_addr_err got=%b exp=1", coef_err); end
    tick();
    n_cmp++; if (coef_err !== 1'b0) begin n_bad++; $display("FAIL rej_addr_pulse got=%b exp=0", coef_err); end
    // Delay line now holds 0x10 at x[0]; next 0x10 gives 0x10*3 + 0x10*1.
    run_sample(8'h10, lat, y);
    n_cmp++; if (y !== 16'h0040) begin n_bad++; $display("FAIL rej_coef_unchanged got=%h exp=0040", y); end
  endtask

  task automatic test_write_with_accept();
    int lat;
    do_reset();
    out_ready  = 1'b1;
    coef_we    = 1'b1;
    coef_addr  = 3'd0;
    coef_wdata = 8'h20;
    in_valid   = 1'b1;
    in_data    = 8'h10;
    tick();
    coef_we  = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (coef_err !== 1'b0) begin n_bad++; $display("FAIL wwa_err got=%b exp=0", coef_err); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
    n_cmp++; if (out_data !== 16'h0200) begin n_bad++; $display("FAIL wwa_data got=%h exp=0200", out_data); end
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL wwa_latency got=%0d exp=6", lat); end
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] y;
    int lat;
    int rises;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();  // now in MAC cycle 3
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_busy got=%b exp=0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL clr_out_data got=%h exp=0000", out_data); end
    rises = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b0) rises++;
      tick();
    end
    n_cmp++; if (rises !== 0) begin n_bad++; $display("FAIL clr_no_valid got=%0d exp=0", rises); end
    // Sample and write presented with clr are both ignored.
    clr        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h44;
    coef_we    = 1'b1;
    coef_addr  = 3'd1;
    coef_wdata = 8'h77;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_sample_ignored got=%b exp=0", busy); end
    n_cmp++; if (coef_err !== 1'b0) begin n_bad++; $display("FAIL clr_coef_err got=%b exp=0", coef_err); end
    run_sample(8'h10, lat, y);
    n_cmp++; if (y !== 16'h0030) begin n_bad++; $display("FAIL clr_impulse got=%h exp=0030", y); end
    run_sample(8'h00, lat, y);
    n_cmp++; if (y !== 16'h0010) begin n_bad++; $display("FAIL clr_h1_kept got=%h exp=0010", y); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] y;
    int lat;
    do_reset();
    out_ready = 1'b1;
    write_coef(3'd0, 8'h20);
    in_valid = 1'b1;
    in_data  = 8'h10;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL rstmid_out_data got=%h exp=0000", out_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    run_sample(8'h10, lat, y);
    n_cmp++; if (y !== 16'h0030) begin n_bad++; $display("FAIL rstmid_coef_default got=%h exp=0030", y); end
  endtask

  initial begin
    rst        = 1'b1;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    test_reset();
    test_impulse();
    test_wrap_sat();
    test_backpressure();
    test_coef_reject();
    test_write_with_accept();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
